contador_scheduler: RTL
=======================

// Module: contador_scheduler
// PURPOSE
//   Shares one up/down counter between NUM_REQ requesters.
//   Each requester asks for one increment or decrement step; a round-robin arbiter grants one request per service slot.
//   A configuration port reloads the count.
//   Sits between the requesting blocks and the count consumers, and replaces direct drive of the counter's up/down inputs.
// PARAMETERS
//   NUM_REQ    4      number of requesters (2..8)
//   WIDTH      8      counter width in bits
//   RESET_VAL  8'h6A  count value after reset
// PORTS
//   clk         in   1              single clock, rising edge
//   rst         in   1              synchronous, active-high reset
//   req_valid   in   NUM_REQ        per-requester step request; held until its req_ready
//   req_dir     in   NUM_REQ        per-requester direction: 1 = +1, 0 = -1; stable while req_valid
//   req_ready   out  NUM_REQ        one-hot grant; high for exactly one cycle
//   cfg_load    in   1              reload request; held until cfg_ack
//   cfg_value   in   WIDTH          reload value; sampled in the cfg_ack cycle
//   cfg_ack     out  1              one-cycle acknowledge of cfg_load
//   count       out  WIDTH          current counter value
//   grant_id    out  $clog2(NUM_REQ) index of the last granted requester
//   busy        out  1              high whenever state != IDLE
//   wrap_pulse  out  1              one-cycle pulse when the count wraps
//   zero        out  1              combinational (count == 0)
// BEHAVIOUR
//   Reset (rst high at a clk edge) takes priority over everything and forces:
//     state=IDLE, count=RESET_VAL, rr_ptr=0, grant_id=0, and req_ready, cfg_ack, wrap_pulse, busy all 0.
//   A grant or load in progress is dropped; count is not updated.
//   FSM states: IDLE, GRANT, LOAD. All outputs are registered except zero.
//   IDLE:
//     - cfg_load=1 -> LOAD. cfg_load beats any pending requests in the same cycle.
//     - else any req_valid=1 -> GRANT. The winner is the first set bit searching from rr_ptr upward, modulo NUM_REQ.
//       req_ready[winner] and grant_id are registered for the GRANT cycle.
//     - else stay in IDLE.
//   GRANT (one cycle; req_ready[winner]=1):
//     - req_valid[winner]=1 -> count steps per req_dir[winner] at the end of this cycle; rr_ptr <= winner+1 mod NUM_REQ.
//     - req_valid[winner]=0 (withdrawn) -> no count change and no rr_ptr change.
//     - Always returns to IDLE.
//   LOAD (one cycle; cfg_ack=1): count <= cfg_value, then -> IDLE. No wrap_pulse on a load.
//   Latency and throughput:
//     - req_valid high in IDLE at cycle t: req_ready at t+1; new count visible at t+2.
//     - Maximum throughput is one step per 2 cycles.
//   Fairness: with all requesters asserting continuously, grants rotate 0,1,2,..,NUM_REQ-1,0,...
//   Arithmetic is modulo 2^WIDTH.
//     - (2^WIDTH-1)+1 -> 0 and 0-1 -> 2^WIDTH-1.
//     - wrap_pulse is high in the cycle the wrapped value first appears on count.
//   Requests arriving while busy wait; nothing is queued beyond req_valid itself.
//   req_valid/req_dir changing during IDLE are legal, and the sampled values win.
//   cfg_value is don't-care outside LOAD.
// CONFIGURATION
//   CONTADOR_SAT_EN defined:
//     - The count saturates: 2^WIDTH-1 up stays 2^WIDTH-1, and 0 down stays 0.
//     - The request is still granted and rr_ptr still advances.
//     - wrap_pulse is tied 0.
//   CONTADOR_SAT_EN undefined: wrap-around with wrap_pulse, as in BEHAVIOUR.
// TESTING
//   1. Reset: rst=1 for 2 cycles with all requests active -> count=8'h6A, req_ready=0, busy=0, cfg_ack=0.
//   2. Single step: req_valid[2]=1, req_dir[2]=1 from IDLE at t -> req_ready=4'b0100 at t+1, count=8'h6B at t+2.
//   3. Round-robin: all 4 requesters held valid, req_dir=0 -> grant order 0,1,2,3,0.
//      count goes 6A->69->68->67->66, one step every 2 cycles.
//   4. Priority and load: cfg_load=1, cfg_value=8'hFF and req_valid[0]=1 in the same IDLE cycle -> LOAD first, count=FF.
//      Then req 0 (dir=1) is granted -> count=00 with wrap_pulse=1 and zero=1.
//      With CONTADOR_SAT_EN defined -> count stays FF and wrap_pulse=0.
//   5. Withdraw and reset mid-operation:
//      - req_valid[1] dropped during its GRANT -> count unchanged, next grant still favours 1.
//      - rst=1 during GRANT -> count=8'h6A next cycle, no step applied.
//   6. Underflow: cfg load 8'h00, then one down step -> count=FF with wrap_pulse=1.
//      With CONTADOR_SAT_EN defined -> count stays 00 and zero stays 1.

Source files
------------

// File: rtl/contador_scheduler.sv
// contador_scheduler
//   Shares one up/down counter between NUM_REQ requesters. A round-robin
//   arbiter grants one +1/-1 step request per service slot. A configuration
//   port reloads the count and takes priority over pending step requests.
//
//   Build option: define CONTADOR_SAT_EN to make the counter saturate at
//   0 / 2^WIDTH-1 instead of wrapping (wrap_pulse is then always 0).
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   req_valid  in   [NUM_REQ]  per-requester step request, held until req_ready
//   req_dir    in   [NUM_REQ]  per-requester direction (1 = +1, 0 = -1)
//   req_ready  out  [NUM_REQ]  one-hot, one-cycle grant
//   cfg_load   in   reload request, held until cfg_ack
//   cfg_value  in   [WIDTH]    reload value, sampled in the cfg_ack cycle
//   cfg_ack    out  one-cycle reload acknowledge
//   count      out  [WIDTH]    current counter value
//   grant_id   out  index of the last granted requester
//   busy       out  high whenever the controller is not idle
//   wrap_pulse out  one-cycle pulse when a wrapped value appears on count
//   zero       out  combinational (count == 0)
module contador_scheduler #(
  parameter int unsigned      NUM_REQ   = 4,
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(8'h6A)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_dir,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       cfg_load,
  input  logic [WIDTH-1:0]           cfg_value,
  output logic                       cfg_ack,
  output logic [WIDTH-1:0]           count,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       wrap_pulse,
  output logic                       zero
);

  localparam int unsigned GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t               state, nxt_state;
  logic [GW-1:0]        rr_ptr, nxt_rr_ptr;
  logic [GW-1:0]        nxt_grant_id;
  logic [NUM_REQ-1:0]   nxt_req_ready;
  logic                 nxt_cfg_ack;
  logic                 nxt_busy;
  logic                 nxt_wrap_pulse;
  logic [WIDTH-1:0]     nxt_count;

  logic [GW-1:0]        win_idx;
  logic                 win_found;
  logic [WIDTH-1:0]     step_count;
  logic                 step_wrap;

  // Round-robin search: first set request at or above rr_ptr, modulo NUM_REQ
  always_comb begin
    int unsigned   idx;
    logic [GW-1:0] cand;
    win_idx   = '0;
    win_found = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx  = (32'(rr_ptr) + i) % NUM_REQ;
      cand = GW'(idx);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Step result for the currently granted requester
  always_comb begin
    step_count = count;
    step_wrap  = 1'b0;
    if (req_dir[grant_id]) begin
      if (count == '1) begin
`ifdef CONTADOR_SAT_EN
        step_count = count;
`else
        step_count = '0;
        step_wrap  = 1'b1;
`endif
      end else begin
        step_count = count + WIDTH'(1);
      end
    end else begin
      if (count == '0) begin
`ifdef CONTADOR_SAT_EN
        step_count = count;
`else
        step_count = '1;
        step_wrap  = 1'b1;
`endif
      end else begin
        step_count = count - WIDTH'(1);
      end
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    nxt_state      = state;
    nxt_count      = count;
    nxt_rr_ptr     = rr_ptr;
    nxt_grant_id   = grant_id;
    nxt_req_ready  = '0;
    nxt_cfg_ack    = 1'b0;
    nxt_busy       = 1'b0;
    nxt_wrap_pulse = 1'b0;

    case (state)
      IDLE: begin
        if (cfg_load) begin
          nxt_state   = LOAD;
          nxt_cfg_ack = 1'b1;
          nxt_busy    = 1'b1;
        end else if (win_found) begin
          nxt_state     = GRANT;
          nxt_req_ready = NUM_REQ'(1) << win_idx;
          nxt_grant_id  = win_idx;
          nxt_busy      = 1'b1;
        end
      end
      GRANT: begin
        nxt_state = IDLE;
        // A withdrawn request leaves both count and pointer untouched
        if (req_valid[grant_id]) begin
          nxt_count      = step_count;
          nxt_wrap_pulse = step_wrap;
          nxt_rr_ptr     = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);
        end
      end
      LOAD: begin
        nxt_state = IDLE;
        nxt_count = cfg_value;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= RESET_VAL;
      rr_ptr     <= '0;
      grant_id   <= '0;
      req_ready  <= '0;
      cfg_ack    <= 1'b0;
      busy       <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= nxt_state;
      count      <= nxt_count;
      rr_ptr     <= nxt_rr_ptr;
      grant_id   <= nxt_grant_id;
      req_ready  <= nxt_req_ready;
      cfg_ack    <= nxt_cfg_ack;
      busy       <= nxt_busy;
      wrap_pulse <= nxt_wrap_pulse;
    end
  end

  assign zero = (count == '0);

endmodule
